shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
Sequential multi-mode shift unit. Executes a shift or rotate by a run-time amount, one bit position per clock, under a start/busy/done handshake. Generalises the basic load/shift register with logical, arithmetic and rotate modes, a multi-bit shift amount and a carry/shifted-out flag. Serves the datapath as a small-area shifter where a barrel shifter is not justified.

Parameters:
W, 8, data width in bits (W >= 2)
SW, 3, shift-amount width in bits (shamt range 0..2^SW-1; values >= W are legal)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
load  input  1  parallel load of data_in into out (IDLE only, no operation)
start  input  1  request an operation (IDLE only)
mode  input  3  operation select, sampled with start
shamt  input  SW  shift amount, sampled with start
data_in  input  W  operand / parallel load value
s_in  input  1  serial fill bit for LSL/LSR, sampled every shift cycle
out  output  W  result register
carry_out  output  1  last bit shifted out
busy  output  1  high while state is SHIFT or DONE
done  output  1  one-cycle pulse when the result is valid

Behaviour:
- Reset (synchronous, highest priority, any state including mid-operation): state=IDLE, out=0, carry_out=0, busy=0, done=0, internal count=0.
- FSM has three states: IDLE, SHIFT, DONE. busy = (state!=IDLE). done = (state==DONE).
- IDLE, load=1: out<=data_in; carry_out unchanged; stay in IDLE; no done. load takes priority over start when both are high.
- IDLE, start=1, load=0: out<=data_in, carry_out<=0, latch mode, count<=shamt. Next state is SHIFT if shamt!=0, else DONE.
- SHIFT, each edge: perform one 1-bit step per the latched mode; count<=count-1. On the edge where count==1, move to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE. start and load are ignored in DONE and in SHIFT (no queueing).
- Latency: the start edge is edge 0. The result is final after edge shamt; done is high in the cycle after edge shamt, which is the cycle after edge 0 when shamt=0. out holds its value in IDLE until the next load/start.
- Modes (one step):
  - 0 LSL: out<={out[W-2:0],s_in}, carry_out<=out[W-1]
  - 1 LSR: out<={s_in,out[W-1:1]}, carry_out<=out[0]
  - 2 ASR: out<={out[W-1],out[W-1:1]}, carry_out<=out[0]
  - 3 ROL: out<={out[W-2:0],out[W-1]}, carry_out<=out[W-1]
  - 4 ROR: out<={out[0],out[W-1:1]}, carry_out<=out[0]
  - 5 LSL0: as LSL with fill forced to 0
  - 6,7 NOP: out and carry_out unchanged. count still decrements and the timing is identical.
- shamt >= W is legal. Shifts continue step by step: LSL0 ends in all zeros, ASR ends in sign replication, rotates wrap modulo W in effect.
- The mode, shamt and data_in inputs are don't-care except on the start edge. s_in is sampled live on each SHIFT edge.
- carry_out stays valid from DONE until the next start, load does not change it.

Test Plan:
- Assert reset 2 cycles, W=8 -> out=0x00, carry_out=0, busy=0, done=0. Then reset during SHIFT of a shamt=5 op -> next cycle state IDLE, out=0, busy=0, no done pulse.
- start, mode=0 LSL, data_in=0x81, shamt=3, s_in=0 -> busy for 4 cycles, done pulses in the cycle after edge 3, out=0x08, carry_out=0. The intermediate carry after step 1 is 1.
- start, mode=2 ASR, data_in=0x90, shamt=2 -> out=0xE4, carry_out=0. Then mode=4 ROR, data_in=0x01, shamt=1 -> out=0x80, carry_out=1.
- start, mode=1 LSR, data_in=0x00, shamt=7, s_in=1 held -> out=0xFE, carry_out=0, done 8 cycles after the start edge.
- start with shamt=0, data_in=0x5A -> done in the very next cycle, out=0x5A, carry_out=0. Load and start high together in IDLE with data_in=0x33 -> out=0x33, no busy, no done.
- Pulse start and load again while busy, with different data_in -> ignored, the original result completes unchanged. mode=6 NOP, shamt=4 -> out=data_in, done after 4 steps.

Source files
------------

// File: rtl/shift_unit_seq_if.sv
// Handshake and data bundle for the sequential shift unit.
// The master drives requests; the slave (the shifter) returns the result and status.
interface shift_unit_seq_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 3
);
  logic          load;
  logic          start;
  logic [2:0]    mode;
  logic [SW-1:0] shamt;
  logic [W-1:0]  data_in;
  logic          s_in;
  logic [W-1:0]  out;
  logic          carry_out;
  logic          busy;
  logic          done;

  modport master (
    output load, start, mode, shamt, data_in, s_in,
    input  out, carry_out, busy, done
  );

  modport slave (
    input  load, start, mode, shamt, data_in, s_in,
    output out, carry_out, busy, done
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Bit-serial shifter/rotator: one position per clock under a start/busy/done handshake.
// Supports LSL, LSR, ASR, ROL, ROR, LSL with zero fill, and a timed NOP.
module shift_unit_seq #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 3
) (
  input logic             clk_i,
  input logic             reset_i,
  shift_unit_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [2:0] ModeLsl  = 3'd0;
  localparam logic [2:0] ModeLsr  = 3'd1;
  localparam logic [2:0] ModeAsr  = 3'd2;
  localparam logic [2:0] ModeRol  = 3'd3;
  localparam logic [2:0] ModeRor  = 3'd4;
  localparam logic [2:0] ModeLsl0 = 3'd5;

  state_e        state_q;
  logic [W-1:0]  out_q, out_d;
  logic          carry_q, carry_d;
  logic [2:0]    mode_q;
  logic [SW-1:0] count_q;

  // Single-step result for the latched mode; s_in is sampled live each step.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    case (mode_q)
      ModeLsl: begin
        out_d   = {out_q[W-2:0], bus.s_in};
        carry_d = out_q[W-1];
      end
      ModeLsr: begin
        out_d   = {bus.s_in, out_q[W-1:1]};
        carry_d = out_q[0];
      end
      ModeAsr: begin
        out_d   = {out_q[W-1], out_q[W-1:1]};
        carry_d = out_q[0];
      end
      ModeRol: begin
        out_d   = {out_q[W-2:0], out_q[W-1]};
        carry_d = out_q[W-1];
      end
      ModeRor: begin
        out_d   = {out_q[0], out_q[W-1:1]};
        carry_d = out_q[0];
      end
      ModeLsl0: begin
        out_d   = {out_q[W-2:0], 1'b0};
        carry_d = out_q[W-1];
      end
      default: begin
        out_d   = out_q;
        carry_d = carry_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      out_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Load wins over start and leaves carry untouched.
          if (bus.load) begin
            out_q <= bus.data_in;
          end else if (bus.start) begin
            out_q   <= bus.data_in;
            carry_q <= 1'b0;
            mode_q  <= bus.mode;
            count_q <= bus.shamt;
            state_q <= (bus.shamt != '0) ? StShift : StDone;
          end
        end
        StShift: begin
          out_q   <= out_d;
          carry_q <= carry_d;
          count_q <= count_q - SW'(1);
          if (count_q == SW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.carry_out = carry_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_shift_unit_seq;

  typedef struct {
    logic [7:0] out;
    logic       c;
    int         edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  shift_unit_seq_if #(.W(8), .SW(3)) bus ();

  shift_unit_seq #(.W(8), .SW(3)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 want no pending op (edge %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_out", {24'd0, bus.out}, {24'd0, e.out});
        check("done_carry", {31'd0, bus.carry_out}, {31'd0, e.c});
        check("done_edge", cyc, e.edge_n);
      end
    end
  end

  task automatic run_op(input logic [2:0] m, input logic [2:0] sa, input logic [7:0] d,
                        input logic sin, input logic [7:0] eo, input logic ec,
                        input bit poke, input int c1_exp);
    int busy_cnt;
    int guard;
    @(negedge clk);
    bus.mode    = m;
    bus.shamt   = sa;
    bus.data_in = d;
    bus.s_in    = sin;
    bus.load    = 1'b0;
    bus.start   = 1'b1;
    sb.push_back('{eo, ec, cyc + 1 + int'(sa)});
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = ~d;
    bus.mode    = 3'd7;
    bus.shamt   = 3'd0;
    busy_cnt = 0;
    guard    = 0;
    while (bus.busy === 1'b1 && guard < 40) begin
      busy_cnt++;
      if (busy_cnt == 2 && c1_exp >= 0)
        check("carry_step1", {31'd0, bus.carry_out}, c1_exp);
      if (poke && busy_cnt == 2) begin
        bus.start   = 1'b1;
        bus.load    = 1'b1;
        bus.data_in = 8'hFF;
      end else begin
        bus.start = 1'b0;
        bus.load  = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    bus.load  = 1'b0;
    check("busy_cycles", busy_cnt, int'(sa) + 1);
    check("hold_out", {24'd0, bus.out}, {24'd0, eo});
  endtask

  initial begin
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 3'd0;
    bus.shamt   = 3'd0;
    bus.data_in = 8'h00;
    bus.s_in    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", {24'd0, bus.out}, 32'h00);
    check("rst_carry", {31'd0, bus.carry_out}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    reset = 1'b0;

    // mode, shamt, data, s_in, exp out, exp carry, poke, carry after step 1
    run_op(3'd0, 3'd3, 8'h81, 1'b0, 8'h08, 1'b0, 1'b0, 1);
    run_op(3'd2, 3'd2, 8'h90, 1'b0, 8'hE4, 1'b0, 1'b0, -1);
    run_op(3'd4, 3'd1, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0, -1);
    run_op(3'd1, 3'd7, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, -1);
    run_op(3'd0, 3'd0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, -1);

    // Load and start together: load wins, no operation, carry kept.
    @(negedge clk);
    bus.load    = 1'b1;
    bus.start   = 1'b1;
    bus.data_in = 8'h33;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    check("load_out", {24'd0, bus.out}, 32'h33);
    check("load_busy", {31'd0, bus.busy}, 0);
    check("load_done", {31'd0, bus.done}, 0);
    check("load_carry", {31'd0, bus.carry_out}, 0);
    @(negedge clk);
    check("load_busy2", {31'd0, bus.busy}, 0);

    run_op(3'd3, 3'd2, 8'h81, 1'b0, 8'h06, 1'b0, 1'b1, 1);
    run_op(3'd6, 3'd4, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, -1);
    run_op(3'd5, 3'd7, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0, 1);

    // Reset in the middle of a shamt=5 operation.
    @(negedge clk);
    bus.mode    = 3'd0;
    bus.shamt   = 3'd5;
    bus.data_in = 8'hFF;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid_busy", {31'd0, bus.busy}, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out", {24'd0, bus.out}, 32'h00);
    check("midrst_busy", {31'd0, bus.busy}, 0);
    check("midrst_done", {31'd0, bus.done}, 0);
    repeat (8) @(negedge clk);
    check("post_rst_busy", {31'd0, bus.busy}, 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
